// File: rtl/circle_scan_ctrl.sv
// Circling-animation sequencer for a multiplexed 7-seg display.
// Scans the digit anodes and tells the segment encoder where the circle is.
module circle_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int STEP_DIV   = 12500000,
  parameter int AN_ACT_LOW = 1,
  localparam int PW = $clog2(2*NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  cw,
  input  logic                  clear,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  row,
  output logic                  en,
  output logic [PW-1:0]         pos,
  output logic                  step_tick
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int TW = $clog2(STEP_DIV);

  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV-1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS-1);
  localparam logic [TW-1:0] STEP_LAST = TW'(STEP_DIV-1);
  localparam logic [PW-1:0] POS_LAST  = PW'(2*NUM_DIGITS-1);
  localparam logic [PW-1:0] POS_HALF  = PW'(NUM_DIGITS);

  localparam logic [NUM_DIGITS-1:0] AN_OFF =
    (AN_ACT_LOW != 0) ? '1 : '0;
  localparam logic [NUM_DIGITS-1:0] AN_ONE =
    {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  logic [SW-1:0]         scan_cnt_q, scan_cnt_d;
  logic [IW-1:0]         scan_idx_q, scan_idx_d;
  logic [TW-1:0]         step_cnt_q, step_cnt_d;
  logic [PW-1:0]         pos_q, pos_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  row_q, row_d;
  logic                  en_q, en_d;
  logic                  tick_q, tick_d;

  logic          scan_wrap;
  logic          step_due;
  logic          step_fire;
  logic          circ_row;
  logic [PW-1:0] circ_digit;

  always_comb begin
    scan_wrap  = (scan_cnt_q == SCAN_LAST);
    scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + 1'b1;
    scan_idx_d = scan_idx_q;
    if (scan_wrap) begin
      scan_idx_d = (scan_idx_q == IDX_LAST) ? '0
                                            : scan_idx_q + 1'b1;
    end

    step_due  = run && (step_cnt_q == STEP_LAST);
    step_fire = step_due && !clear;

    step_cnt_d = step_cnt_q;
    if (clear || step_due) begin
      step_cnt_d = '0;
    end else if (run) begin
      step_cnt_d = step_cnt_q + 1'b1;
    end

    pos_d = pos_q;
    if (clear) begin
      pos_d = '0;
    end else if (step_fire) begin
      if (cw) begin
        pos_d = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
      end else begin
        pos_d = (pos_q == '0) ? POS_LAST : pos_q - 1'b1;
      end
    end

    // Top half of the loop walks right on row 1, bottom half walks back.
    circ_row   = (pos_q < POS_HALF);
    circ_digit = circ_row ? pos_q : POS_LAST - pos_q;

    an_d   = AN_OFF ^ (AN_ONE << scan_idx_q);
    en_d   = (PW'(scan_idx_q) == circ_digit);
    row_d  = circ_row;
    tick_d = step_fire;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
      step_cnt_q <= '0;
      pos_q      <= '0;
      an_q       <= AN_OFF;
      row_q      <= 1'b0;
      en_q       <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      scan_idx_q <= scan_idx_d;
      step_cnt_q <= step_cnt_d;
      pos_q      <= pos_d;
      an_q       <= an_d;
      row_q      <= row_d;
      en_q       <= en_d;
      tick_q     <= tick_d;
    end
  end

  assign an        = an_q;
  assign row       = row_q;
  assign en        = en_q;
  assign pos       = pos_q;
  assign step_tick = tick_q;

endmodule

// File: tb/tb_circle_scan_ctrl.sv
// Directed bench for circle_scan_ctrl with a 4-digit display,
// 4-cycle scan slots and 10-cycle animation steps.
module tb_circle_scan_ctrl;

  logic       clk;
  logic       rst;
  logic       run;
  logic       cw;
  logic       clear;
  logic [3:0] an;
  logic       row;
  logic       en;
  logic [2:0] pos;
  logic       step_tick;

  int total;
  int bad;
  int k;
  int prev_pos;
  int ticks;

  // digit carrying the circle, and its row, for each loop position
  int dig[8] = '{0, 1, 2, 3, 3, 2, 1, 0};
  int rw[8]  = '{1, 1, 1, 1, 0, 0, 0, 0};
  logic [3:0] an_tab[4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  circle_scan_ctrl #(
    .NUM_DIGITS(4),
    .SCAN_DIV  (4),
    .STEP_DIV  (10),
    .AN_ACT_LOW(1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .cw       (cw),
    .clear    (clear),
    .an       (an),
    .row      (row),
    .en       (en),
    .pos      (pos),
    .step_tick(step_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s k=%0d observed=%0h expected=%0h",
             tag, k, obs, exp);
    end
  endtask

  task automatic chk_reset();
    @(posedge clk); #1;
    chk("rst_an", 32'(an), 32'h0000_000f);
    chk("rst_en", 32'(en), 0);
    chk("rst_row", 32'(row), 0);
    chk("rst_pos", 32'(pos), 0);
    chk("rst_tick", 32'(step_tick), 0);
  endtask

  // One clock: pos/tick as given, an/en/row from the slot and
  // position that held before this edge.
  task automatic cyc(input int ep, input bit et);
    int slot;
    @(posedge clk); #1;
    k++;
    slot = ((k - 1) / 4) % 4;
    chk("pos", 32'(pos), 32'(ep));
    chk("tick", 32'(step_tick), 32'(et));
    chk("an", 32'(an), 32'(an_tab[slot]));
    chk("en", 32'(en), 32'(slot == dig[prev_pos]));
    if (slot == dig[prev_pos])
      chk("row", 32'(row), 32'(rw[prev_pos]));
    if (step_tick) ticks++;
    prev_pos = ep;
  endtask

  initial begin
    total = 0;
    bad = 0;
    ticks = 0;
    rst = 1'b1;
    run = 1'b0;
    cw = 1'b1;
    clear = 1'b0;

    for (int i = 0; i < 3; i++) chk_reset();
    rst = 1'b0;
    k = 0;
    prev_pos = 0;

    // scan only
    for (int i = 1; i <= 32; i++) cyc(0, 0);

    // forward lap
    run = 1'b1;
    cw = 1'b1;
    for (int i = 1; i <= 80; i++)
      cyc((i / 10) % 8, (i % 10) == 0);
    chk("tick_count", 32'(ticks), 8);

    // one reverse step wraps 0 -> 7
    cw = 1'b0;
    for (int i = 1; i <= 9; i++) cyc(0, 0);
    cyc(7, 1);

    // pause with step_cnt at 6
    for (int i = 1; i <= 6; i++) cyc(7, 0);
    run = 1'b0;
    for (int i = 1; i <= 20; i++) cyc(7, 0);
    run = 1'b1;
    for (int i = 1; i <= 3; i++) cyc(7, 0);
    cyc(6, 1);

    // walk down to pos 3
    for (int i = 1; i <= 9; i++) cyc(6, 0);
    cyc(5, 1);
    for (int i = 1; i <= 9; i++) cyc(5, 0);
    cyc(4, 1);
    for (int i = 1; i <= 9; i++) cyc(4, 0);
    cyc(3, 1);

    // clear collides with a due step
    for (int i = 1; i <= 9; i++) cyc(3, 0);
    clear = 1'b1;
    cyc(0, 0);
    clear = 1'b0;
    for (int i = 1; i <= 9; i++) cyc(0, 0);
    cyc(7, 1);

    // reset mid-step and mid-scan
    for (int i = 1; i <= 5; i++) cyc(7, 0);
    rst = 1'b1;
    chk_reset();
    rst = 1'b0;
    k = 0;
    prev_pos = 0;
    cw = 1'b1;
    for (int i = 1; i <= 9; i++) cyc(0, 0);
    cyc(1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
